// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with byte-lane writes, one-cycle read latency,
// range/alignment error flags, saturating access counters and optional clear-on-reset.
module data_sram_responder #(
  parameter int unsigned DEPTH          = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        clr_busy,
  output logic        err_range,
  output logic        err_misalign,
  input  logic        err_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_range_q, err_range_d;
  logic        err_mis_q, err_mis_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]   offs;
  logic          in_range;
  logic          misalign;
  logic [AW-1:0] idx;
  logic          serve;
  logic          is_wr;
  logic          wr_ok;
  logic          rd_inc;
  logic          clr_we;
  logic [31:0]   rd_word;

  // Offset wraps for addresses below BASE_ADDR, so one compare covers both sides.
  assign offs     = data_sram_addr - BASE_ADDR;
  assign in_range = {1'b0, offs} < SPAN;
  assign misalign = |data_sram_addr[1:0];
  assign idx      = offs[AW+1:2];
  assign rd_word  = mem[idx];

  assign serve  = (state_q == S_IDLE) && data_sram_en;
  assign is_wr  = |data_sram_we;
  assign wr_ok  = serve && is_wr && in_range && !misalign;
  assign rd_inc = serve && !is_wr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (serve) begin
      rdata_d = in_range ? rd_word : 32'h0;
    end
  end

  // A new fault in the same cycle as err_clr leaves the flag set.
  always_comb begin
    err_range_d = err_range_q && !err_clr;
    err_mis_d   = err_mis_q && !err_clr;
    if (serve && !in_range) begin
      err_range_d = 1'b1;
    end
    if (serve && misalign) begin
      err_mis_d = 1'b1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_inc && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (wr_ok && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      ptr_q       <= '0;
      rdata_q     <= '0;
      err_range_q <= 1'b0;
      err_mis_q   <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
      err_range_q <= err_range_d;
      err_mis_q   <= err_mis_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // Array is not reset; it is only zeroed by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= 32'h0;
    end else if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign clr_busy        = (state_q == S_CLEAR);
  assign err_range       = err_range_q;
  assign err_misalign    = err_mis_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule
